// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment pattern constants, FSM state types and pattern decoder
package seg7_pkg;

  typedef logic [6:0] seg_t;

  // Active-low patterns, bit0 = a .. bit6 = g
  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b0000011;
  localparam seg_t SEG_C = 7'b1000110;
  localparam seg_t SEG_D = 7'b0100001;
  localparam seg_t SEG_E = 7'b0000110;
  localparam seg_t SEG_F = 7'b0001110;

  typedef enum logic {WAIT_STABLE, ARMED} cap_state_e;
  typedef enum logic {EMPTY, FULL} out_state_e;

  // Returns {legal, nibble}; unknown patterns come back with legal = 0
  function automatic logic [4:0] seg_to_nibble(seg_t s);
    case (s)
      SEG_0:   return {1'b1, 4'h0};
      SEG_1:   return {1'b1, 4'h1};
      SEG_2:   return {1'b1, 4'h2};
      SEG_3:   return {1'b1, 4'h3};
      SEG_4:   return {1'b1, 4'h4};
      SEG_5:   return {1'b1, 4'h5};
      SEG_6:   return {1'b1, 4'h6};
      SEG_7:   return {1'b1, 4'h7};
      SEG_8:   return {1'b1, 4'h8};
      SEG_9:   return {1'b1, 4'h9};
      SEG_A:   return {1'b1, 4'hA};
      SEG_B:   return {1'b1, 4'hB};
      SEG_C:   return {1'b1, 4'hC};
      SEG_D:   return {1'b1, 4'hD};
      SEG_E:   return {1'b1, 4'hE};
      SEG_F:   return {1'b1, 4'hF};
      default: return {1'b0, 4'h0};
    endcase
  endfunction

endpackage

// File: rtl/seg7_sync.sv
// rtl/seg7_sync.sv - parameterised-width two-flop synchronizer
module seg7_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - samples a multiplexed active-low 7-segment bus and rebuilds hex frames
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    illegal_seg,
  output logic                    bus_err
);

  localparam int                  CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam int                  SMP_W   = 7 + NUM_DIGITS;
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);

  logic [SMP_W-1:0] smp;
  logic [6:0]       s_seg;
  logic [NUM_DIGITS-1:0] s_dig;

  seg7_sync #(.W(SMP_W)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({seg_in, dig_sel}),
    .q_o   (smp)
  );

  assign s_seg = smp[SMP_W-1:NUM_DIGITS];
  assign s_dig = smp[NUM_DIGITS-1:0];

  logic [SMP_W-1:0]                 prev_q;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  cap_state_e                       cap_q, cap_d;
  out_state_e                       out_q, out_d;
  logic [NUM_DIGITS-1:0][3:0]       slot_q, slot_d;
  logic [NUM_DIGITS-1:0]            dv_q, dv_d;
  logic [4*NUM_DIGITS-1:0]          val_q, val_d;
  logic                             ill_q, ill_d;
  logic                             bus_q, bus_d;

  logic       changed;
  logic       do_cap;
  logic [4:0] dec;
  logic       dig_any;
  logic       dig_multi;

  assign changed   = (smp != prev_q);
  assign dec       = seg_to_nibble(s_seg);
  assign dig_any   = |s_dig;
  assign dig_multi = dig_any && ((s_dig & (s_dig - DIG_ONE)) != '0);

  always_comb begin
    cnt_d  = cnt_q;
    cap_d  = cap_q;
    do_cap = 1'b0;
    out_d  = out_q;
    slot_d = slot_q;
    dv_d   = dv_q;
    val_d  = val_q;
    ill_d  = ill_q;
    bus_d  = bus_q;

    if (changed) begin
      cnt_d = '0;
      cap_d = WAIT_STABLE;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      if (cap_q == WAIT_STABLE && cnt_q == CNT_MAX) begin
        cap_d  = ARMED;
        do_cap = 1'b1;
      end
    end

    // Frame handoff runs before capture so a same-edge capture re-sets its bit
    if (out_q == EMPTY && (&dv_q)) begin
      val_d = slot_q;
      out_d = FULL;
      dv_d  = '0;
    end else if (out_q == FULL && out_ready) begin
      out_d = EMPTY;
    end

    if (do_cap && dig_any) begin
      if (dig_multi) begin
        bus_d = 1'b1;
      end else if (!dec[4]) begin
        ill_d = 1'b1;
      end else begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (s_dig[i]) begin
            slot_d[i] = dec[3:0];
            dv_d[i]   = 1'b1;
          end
        end
      end
    end

    // clear flushes bookkeeping but leaves captured data and the stability tracker alone
    if (clear) begin
      slot_d = slot_q;
      val_d  = val_q;
      dv_d   = '0;
      out_d  = EMPTY;
      ill_d  = 1'b0;
      bus_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      cnt_q  <= '0;
      cap_q  <= WAIT_STABLE;
      out_q  <= EMPTY;
      slot_q <= '0;
      dv_q   <= '0;
      val_q  <= '0;
      ill_q  <= 1'b0;
      bus_q  <= 1'b0;
    end else begin
      prev_q <= smp;
      cnt_q  <= cnt_d;
      cap_q  <= cap_d;
      out_q  <= out_d;
      slot_q <= slot_d;
      dv_q   <= dv_d;
      val_q  <= val_d;
      ill_q  <= ill_d;
      bus_q  <= bus_d;
    end
  end

  assign value_out   = val_q;
  assign out_valid   = (out_q == FULL);
  assign digit_valid = dv_q;
  assign illegal_seg = ill_q;
  assign bus_err     = bus_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - directed self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0010000;
  localparam logic [6:0] PA = 7'b0001000;
  localparam logic [6:0] PD = 7'b0100001;
  localparam logic [6:0] PBAD = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = 7'h7F;
  logic [3:0]  dig_sel = 4'b0000;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] value_out;
  logic        out_valid;
  logic [3:0]  digit_valid;
  logic        illegal_seg;
  logic        bus_err;

  int n_chk = 0;
  int n_pass = 0;
  int hs_cnt = 0;
  logic [15:0] hs_val = '0;

  seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .clear       (clear),
    .value_out   (value_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .digit_valid (digit_valid),
    .illegal_seg (illegal_seg),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      hs_cnt = hs_cnt + 1;
      hs_val = value_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic show(input int d, input logic [6:0] s, input int n);
    dig_sel = 4'b0001 << d;
    seg_in  = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                      input logic [6:0] p2, input logic [6:0] p3);
    show(0, p0, 20);
    show(1, p1, 20);
    show(2, p2, 20);
    show(3, p3, 20);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    dig_sel = 4'b0000;
    seg_in  = 7'h7F;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int base;

    // 1: reset values and capture latency from reset release
    seg_in  = P3;
    dig_sel = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    check("rst_value_out", value_out, 16'h0000);
    check("rst_out_valid", out_valid, 0);
    check("rst_digit_valid", digit_valid, 0);
    check("rst_illegal", illegal_seg, 0);
    check("rst_bus_err", bus_err, 0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("latency_edge9_no_capture", digit_valid, 4'b0000);
    @(posedge clk);
    #1 check("latency_edge10_capture", digit_valid, 4'b0001);

    // 2: two full scans with consumer always ready
    do_reset();
    out_ready = 1'b1;
    base = hs_cnt;
    scan(P3, P6, PA, PD);
    check("scan1_handshakes", hs_cnt - base, 1);
    scan(P3, P6, PA, PD);
    check("scan2_handshakes", hs_cnt - base, 2);
    check("scan_hs_value", hs_val, 16'hDA63);
    check("scan_value_out", value_out, 16'hDA63);
    check("scan_dv_cleared", digit_valid, 4'b0000);
    check("scan_valid_low", out_valid, 0);

    // 3: pattern toggling faster than the stability window
    do_reset();
    for (int k = 0; k < 8; k++) show(1, (k % 2 == 0) ? P1 : P2, 5);
    check("toggle_no_capture", digit_valid, 4'b0000);

    // 4: illegal pattern and multi-hot select
    do_reset();
    show(2, PBAD, 20);
    check("illegal_set", illegal_seg, 1);
    check("illegal_no_slot", digit_valid, 4'b0000);
    show(2, P5, 20);
    check("illegal_sticky", illegal_seg, 1);
    check("legal_after_illegal", digit_valid, 4'b0100);
    dig_sel = 4'b0011;
    seg_in  = P1;
    repeat (20) @(posedge clk);
    #1;
    check("bus_err_set", bus_err, 1);
    check("bus_err_no_slot", digit_valid, 4'b0100);

    // 5: back-pressure across two scans
    do_reset();
    out_ready = 1'b0;
    scan(P1, P2, P3, P4);
    check("bp_first_valid", out_valid, 1);
    check("bp_first_value", value_out, 16'h4321);
    scan(P5, P6, P7, P8);
    check("bp_hold_value", value_out, 16'h4321);
    check("bp_hold_valid", out_valid, 1);
    check("bp_next_ready", digit_valid, 4'b1111);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp_accept_drop", out_valid, 0);
    @(posedge clk);
    #1;
    check("bp_reload_valid", out_valid, 1);
    check("bp_reload_value", value_out, 16'h8765);
    check("bp_reload_dv", digit_valid, 4'b0000);

    // 6: clear while FULL with a partial frame and both flags set
    show(0, P9, 20);
    show(1, P0, 20);
    check("clr_partial_dv", digit_valid, 4'b0011);
    show(2, PBAD, 20);
    dig_sel = 4'b0011;
    seg_in  = P1;
    repeat (20) @(posedge clk);
    #1;
    check("clr_flags_pre", {illegal_seg, bus_err}, 2'b11);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    check("clr_valid", out_valid, 0);
    check("clr_dv", digit_valid, 4'b0000);
    check("clr_flags", {illegal_seg, bus_err}, 2'b00);
    check("clr_value_kept", value_out, 16'h8765);
    scan(P9, P0, P1, P2);
    check("clr_fresh_valid", out_valid, 1);
    check("clr_fresh_value", value_out, 16'h2109);

    // asynchronous reset with a frame pending
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_value", value_out, 16'h0000);
    check("async_rst_dv", digit_valid, 4'b0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
